// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load port and a stallable shift.
// A new word can be taken on the last-bit cycle, so consecutive words stream with no gap.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             at_last;
    logic             transfer;
    logic [WIDTH-1:0] shifted;

    assign at_last  = (bit_cnt == LAST_CNT);
    assign transfer = load_valid && load_ready;
    assign shifted  = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};

    // Ready is gated by reset so nothing can be offered while the block is held in reset.
    always_comb begin
        load_ready = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        if (state == IDLE) begin
            load_ready = reset;
        end else begin
            load_ready = reset && en && at_last;
            ser_out    = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
            ser_valid  = en;
            ser_last   = en && at_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        shift_reg <= load_data;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        if (!at_last) begin
                            shift_reg <= shifted;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end else if (transfer) begin
                            shift_reg <= load_data;
                            bit_cnt   <= '0;
                        end else begin
                            shift_reg <= '0;
                            bit_cnt   <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
